mem_rw_fsm: RTL and testbench



---
 rtl/mem_rw_fsm_pkg.sv | 16 +
 rtl/mem_rw_fsm_if.sv | 20 ++
 rtl/mem_rw_regfile.sv | 30 +++
 rtl/mem_rw_fsm.sv | 91 +++++++++
 tb/tb_mem_rw_fsm.sv | 137 +++++++++++++
 5 files changed

// File: rtl/mem_rw_fsm_pkg.sv
// Shared types and sizing for the mem_rw_fsm register-file controller.
package mem_rw_fsm_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;

    localparam logic [DATA_W-1:0] RESET_DATA_DEFAULT = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_rw_fsm_if.sv
// Bit-level host bus of mem_rw_fsm: strobes, address, write data and read data.
interface mem_rw_fsm_if;

    logic R;
    logic W;
    logic adr0, adr1, adr2;
    logic i0, i1, i2, i3, i4, i5, i6, i7;
    logic o0, o1, o2, o3, o4, o5, o6, o7;

    modport master (
        output R, W, adr0, adr1, adr2, i0, i1, i2, i3, i4, i5, i6, i7,
        input  o0, o1, o2, o3, o4, o5, o6, o7
    );

    modport slave (
        input  R, W, adr0, adr1, adr2, i0, i1, i2, i3, i4, i5, i6, i7,
        output o0, o1, o2, o3, o4, o5, o6, o7
    );

endinterface

// File: rtl/mem_rw_regfile.sv
// 8x8 register file: async active-low clear, synchronous write, combinational read.
module mem_rw_regfile
    import mem_rw_fsm_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_DATA = RESET_DATA_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= RESET_DATA;
            end
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mem_rw_fsm.sv
// Controller sequencing single-word writes/reads into mem_rw_regfile over a bit-level bus.
// Define WRITE_THROUGH_EN to also load o with the written word on each write commit.
module mem_rw_fsm
    import mem_rw_fsm_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_DATA = RESET_DATA_DEFAULT
) (
    input logic         CLK,
    input logic         RST_N,
    mem_rw_fsm_if.slave bus
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] out_q, out_d;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic [DATA_W-1:0] rd_data;
    logic              cap_addr, cap_data, mem_we, out_load;

    assign cmd_addr = {bus.adr2, bus.adr1, bus.adr0};
    assign cmd_data = {bus.i7, bus.i6, bus.i5, bus.i4, bus.i3, bus.i2, bus.i1, bus.i0};

    // R and W together is an illegal command and is treated exactly like no command.
    always_comb begin
        state_d  = state_q;
        cap_addr = 1'b0;
        cap_data = 1'b0;
        mem_we   = 1'b0;
        out_load = 1'b0;
        out_d    = out_q;
        case (state_q)
            IDLE: begin
                if (bus.W && !bus.R) begin
                    cap_addr = 1'b1;
                    cap_data = 1'b1;
                    state_d  = WRITE;
                end else if (bus.R && !bus.W) begin
                    cap_addr = 1'b1;
                    state_d  = READ;
                end
            end
            WRITE: begin
                mem_we  = 1'b1;
                state_d = IDLE;
`ifdef WRITE_THROUGH_EN
                out_load = 1'b1;
                out_d    = data_q;
`else
                out_load = 1'b0;
`endif
            end
            READ: begin
                out_load = 1'b1;
                out_d    = rd_data;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            out_q   <= RESET_DATA;
        end else begin
            state_q <= state_d;
            if (cap_addr) addr_q <= cmd_addr;
            if (cap_data) data_q <= cmd_data;
            if (out_load) out_q  <= out_d;
        end
    end

    mem_rw_regfile #(
        .RESET_DATA (RESET_DATA)
    ) u_regfile (
        .clk     (CLK),
        .rst_n   (RST_N),
        .we      (mem_we),
        .wr_addr (addr_q),
        .wr_data (data_q),
        .rd_addr (addr_q),
        .rd_data (rd_data)
    );

    assign {bus.o7, bus.o6, bus.o5, bus.o4, bus.o3, bus.o2, bus.o1, bus.o0} = out_q;

endmodule

// File: tb/tb_mem_rw_fsm.sv
// Directed, table-driven bench for mem_rw_fsm plus hand sequences for reset and pipeline corners.
module tb_mem_rw_fsm;

    typedef struct {
        logic        r;
        logic        w;
        logic [2:0]  addr;
        logic [7:0]  data;
        int          cycles;
        bit          check;
        logic [7:0]  expected;
        string       name;
    } vec_t;

    logic CLK;
    logic RST_N;
    int   checks;
    int   errors;
    vec_t vecs[$];

    mem_rw_fsm_if bus ();

    mem_rw_fsm dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] get_o();
        return {bus.o7, bus.o6, bus.o5, bus.o4, bus.o3, bus.o2, bus.o1, bus.o0};
    endfunction

    // Inputs change on the falling edge so each rising edge sees stable values.
    task automatic applyStimulus(input logic r, input logic w, input logic [2:0] addr,
                                 input logic [7:0] data, input int cycles);
        bus.R = r;
        bus.W = w;
        {bus.adr2, bus.adr1, bus.adr0} = addr;
        {bus.i7, bus.i6, bus.i5, bus.i4, bus.i3, bus.i2, bus.i1, bus.i0} = data;
        repeat (cycles) @(negedge CLK);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] expected);
        logic [7:0] actual;
        actual = get_o();
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: o=%02h expected %02h", name, actual, expected);
        end
    endtask

    function automatic void add_vec(input logic r, input logic w, input logic [2:0] addr,
                                    input logic [7:0] data, input int cycles, input bit check,
                                    input logic [7:0] expected, input string name);
        vec_t v;
        v.r = r; v.w = w; v.addr = addr; v.data = data; v.cycles = cycles;
        v.check = check; v.expected = expected; v.name = name;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [7:0] wt_expect;
        checks = 0;
        errors = 0;

        // Vector table: {R, W, addr, data, cycles held, check?, expected o, name}
        for (int k = 0; k < 8; k++)
            add_vec(1'b1, 1'b0, 3'(k), 8'h00, 2, 1'b1, 8'h00, $sformatf("rst_read_a%0d", k));
        add_vec(1'b0, 1'b1, 3'd0, 8'd73, 2, 1'b0, 8'h00, "wr_a0_73");
        add_vec(1'b0, 1'b1, 3'd1, 8'd97, 2, 1'b0, 8'h00, "wr_a1_97");
        add_vec(1'b1, 1'b0, 3'd0, 8'h00, 2, 1'b1, 8'd73, "rd_a0_73");
        add_vec(1'b1, 1'b0, 3'd1, 8'h00, 2, 1'b1, 8'd97, "rd_a1_97");
        for (int k = 0; k < 8; k++)
            add_vec(1'b0, 1'b1, 3'(k), 8'hA0 + 8'(k), 2, 1'b0, 8'h00, $sformatf("wr_all_a%0d", k));
        for (int k = 7; k >= 0; k--)
            add_vec(1'b1, 1'b0, 3'(k), 8'h00, 2, 1'b1, 8'hA0 + 8'(k), $sformatf("rd_all_a%0d", k));
        add_vec(1'b1, 1'b1, 3'd2, 8'hFF, 4, 1'b1, 8'hA0, "illegal_o_hold");
        add_vec(1'b0, 1'b0, 3'd2, 8'hFF, 2, 1'b1, 8'hA0, "idle_o_hold");
        add_vec(1'b1, 1'b0, 3'd2, 8'h00, 2, 1'b1, 8'hA2, "illegal_no_write_a2");
        add_vec(1'b0, 1'b1, 3'd5, 8'h5A, 4, 1'b0, 8'h00, "wr_a5_held_long");
        add_vec(1'b1, 1'b0, 3'd5, 8'h00, 2, 1'b1, 8'h5A, "rd_a5_5A");

        // Reset asserted mid-cycle forces o to RESET_DATA immediately.
        RST_N = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 0);
        #2 RST_N = 1'b0;
        #1 checkOutput("reset_async_o", 8'h00);
        @(negedge CLK);
        @(negedge CLK);
        checkOutput("reset_held_o", 8'h00);
        RST_N = 1'b1;

        foreach (vecs[n]) begin
            applyStimulus(vecs[n].r, vecs[n].w, vecs[n].addr, vecs[n].data, vecs[n].cycles);
            if (vecs[n].check) checkOutput(vecs[n].name, vecs[n].expected);
        end

        // Write-through: o follows the write only when the feature is built in.
`ifdef WRITE_THROUGH_EN
        wt_expect = 8'h3C;
`else
        wt_expect = 8'h5A;
`endif
        applyStimulus(1'b0, 1'b1, 3'd4, 8'h3C, 2);
        checkOutput("write_through_o", wt_expect);
        applyStimulus(1'b1, 1'b0, 3'd4, 8'h00, 2);
        checkOutput("rd_a4_3C", 8'h3C);

        // Inputs changed during WRITE are ignored; captured addr/data are committed.
        applyStimulus(1'b0, 1'b1, 3'd6, 8'h11, 1);
        applyStimulus(1'b0, 1'b0, 3'd7, 8'h22, 1);
        applyStimulus(1'b1, 1'b0, 3'd6, 8'h00, 2);
        checkOutput("captured_wr_a6", 8'h11);
        applyStimulus(1'b1, 1'b0, 3'd7, 8'h00, 2);
        checkOutput("untouched_a7", 8'hA7);

        // Reset between capture and commit aborts the write and clears memory.
        applyStimulus(1'b0, 1'b1, 3'd3, 8'h55, 1);
        #2 RST_N = 1'b0;
        #1 checkOutput("reset_midop_o", 8'h00);
        applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 1);
        RST_N = 1'b1;
        applyStimulus(1'b1, 1'b0, 3'd3, 8'h00, 2);
        checkOutput("aborted_wr_a3", 8'h00);
        applyStimulus(1'b1, 1'b0, 3'd7, 8'h00, 2);
        checkOutput("cleared_a7", 8'h00);
        applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
